instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
Instruction fetch stage of the micro-datapath. It sits directly upstream of the program memory. It owns the program counter, drives the memory address/read strobes, latches the returned instruction word into an instruction register, and hands that word to the datapath with a valid/done handshake. It also computes the next PC, sequential or Bicc branch target, and halts on the all-zero "fin" word.

Parameters:
DATAWIDTH_BUS, 32, width of the address bus, data bus, PC and IR.
RESET_PC, 32'h0000_0800, PC value loaded on reset (first program word).
PC_STEP, 4, byte increment for sequential fetch.

Ports:
CLOCK_50  input  1  system clock, rising-edge active.
RESET_InHigh  input  1  asynchronous, active-high reset.
fetch_Enable  input  1  1 = advance the FSM; 0 = freeze all state (stall).
fetch_ExecDone  input  1  datapath finished executing the current IR; one-cycle pulse.
fetch_BranchTaken  input  1  branch condition true for the current IR; sampled only with fetch_ExecDone.
BusDatos  input  DATAWIDTH_BUS  instruction word returned by program memory (combinational).
BusDirecciones  output  DATAWIDTH_BUS  address to program memory.
RD  output  1  memory read strobe.
WR  output  1  memory write strobe; constant 0.
fetch_IR  output  DATAWIDTH_BUS  latched instruction word.
fetch_IRValid  output  1  fetch_IR holds a valid instruction awaiting execution.
fetch_PC  output  DATAWIDTH_BUS  address of the instruction in fetch_IR.
fetch_Halt  output  1  "fin" word (32'h0) fetched; the unit is stopped.

Behaviour:
- Reset (asynchronous, active-high, any state) forces:
  - state = IDLE; PC = RESET_PC; fetch_IR = 0.
  - fetch_IRValid = 0; fetch_Halt = 0; RD = 0; WR = 0; BusDirecciones = 0.
- All outputs are registered or decoded from the registered state only. BusDirecciones = PC while RD = 1, otherwise 0.
- FSM states: IDLE, FETCH, ISSUE, HALT.
  - IDLE: RD=0. Goes to FETCH on the next edge with fetch_Enable=1.
  - FETCH: RD=1, BusDirecciones=PC.
    - On the edge leaving FETCH, the block captures BusDatos into fetch_IR (memory is combinational; one cycle of address setup is enough).
    - If BusDatos == 0: go to HALT.
    - Else: go to ISSUE.
    - FETCH lasts exactly one enabled cycle.
  - ISSUE: fetch_IRValid=1, RD=0, fetch_PC=PC. The block waits for fetch_ExecDone=1, then updates PC and goes to FETCH.
  - HALT: fetch_Halt=1, fetch_IRValid=0, RD=0. Only reset leaves this state; fetch_ExecDone is ignored.
- Next-PC rule, applied on the ISSUE exit edge:
  - The IR is a Bicc when IR[31:30]==2'b00 and IR[24:22]==3'b010.
  - If it is a Bicc and fetch_BranchTaken=1: PC <= PC + (sign_extend(IR[21:0]) << 2).
  - Otherwise: PC <= PC + PC_STEP.
  - Arithmetic is modulo 2^DATAWIDTH_BUS; wrap-around is silent.
  - fetch_BranchTaken is ignored for non-Bicc words.
- Latency: 2 cycles from entering FETCH to fetch_IRValid=1. Minimum instruction period is 2 cycles, when fetch_ExecDone is asserted in the first ISSUE cycle.
- Stall: while fetch_Enable=0, state, PC and IR hold and all outputs hold their current values. A fetch_ExecDone pulse during a stall is lost; the datapath must hold it until Enable returns.
- fetch_ExecDone outside ISSUE is ignored.
- When reset is asserted mid-FETCH or mid-ISSUE, the instruction is discarded with no PC update, and RD drops asynchronously.

Test Plan:
- Reset then Enable=1, memory returns 32'h8280_2001 at 0x800:
  - RD=1 with BusDirecciones=0x800 in cycle 1.
  - fetch_IR=32'h8280_2001, fetch_IRValid=1, fetch_PC=0x800 in cycle 2.
  - After ExecDone, next fetch address is 0x804.
- Bicc at 0x820, IR=32'h0CBF_FFFC (bneg, disp -4), ExecDone with BranchTaken=1 -> next fetch address 0x810. Same word with BranchTaken=0 -> 0x824.
- IR=32'h10BF_FFFB (ba -5) at 0x838, BranchTaken=1 -> next address 0x824. Non-Bicc addcc word with BranchTaken=1 -> PC+4.
- Fetch at 0x83C returns 32'h0:
  - fetch_Halt=1, fetch_IRValid=0, RD=0 from the next cycle.
  - Further ExecDone pulses change nothing.
  - Reset returns PC to 0x800.
- fetch_Enable=0 for 3 cycles in FETCH and in ISSUE -> PC, IR, RD and BusDirecciones unchanged; progress resumes on the first enabled edge.
- RESET_InHigh asserted mid-cycle during ISSUE at PC=0x818 -> outputs go to reset values before the next edge, and the first fetch after release is at 0x800.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads program memory, latches the IR and
// hands it to the datapath; halts permanently on the all-zero "fin" word.
module instruction_fetch_unit #(
    parameter int                       DATAWIDTH_BUS = 32,
    parameter logic [DATAWIDTH_BUS-1:0] RESET_PC      = 'h0000_0800,
    parameter int                       PC_STEP       = 4
) (
    input  logic                     CLOCK_50,
    input  logic                     RESET_InHigh,
    input  logic                     fetch_Enable,
    input  logic                     fetch_ExecDone,
    input  logic                     fetch_BranchTaken,
    input  logic [DATAWIDTH_BUS-1:0] BusDatos,
    output logic [DATAWIDTH_BUS-1:0] BusDirecciones,
    output logic                     RD,
    output logic                     WR,
    output logic [DATAWIDTH_BUS-1:0] fetch_IR,
    output logic                     fetch_IRValid,
    output logic [DATAWIDTH_BUS-1:0] fetch_PC,
    output logic                     fetch_Halt
);

    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALT} state_t;

    state_t                   state;
    logic [DATAWIDTH_BUS-1:0] pc;
    logic [DATAWIDTH_BUS-1:0] disp;
    logic [DATAWIDTH_BUS-1:0] next_pc;
    logic                     is_bicc;

    // Bicc: op=00, op2=010; 22-bit word displacement sign-extended to bytes.
    always_comb begin
        is_bicc = (fetch_IR[31:30] == 2'b00) && (fetch_IR[24:22] == 3'b010);
        disp    = {{(DATAWIDTH_BUS-24){fetch_IR[21]}}, fetch_IR[21:0], 2'b00};
        next_pc = (is_bicc && fetch_BranchTaken) ? pc + disp
                                                 : pc + DATAWIDTH_BUS'(PC_STEP);
    end

    assign WR       = 1'b0;
    assign fetch_PC = pc;

    // Outputs are set alongside the state they belong to, so every output is
    // a flop and reset clears them all asynchronously (RD drops immediately).
    always_ff @(posedge CLOCK_50 or posedge RESET_InHigh) begin
        if (RESET_InHigh) begin
            state          <= IDLE;
            pc             <= RESET_PC;
            fetch_IR       <= '0;
            fetch_IRValid  <= 1'b0;
            fetch_Halt     <= 1'b0;
            RD             <= 1'b0;
            BusDirecciones <= '0;
        end else if (fetch_Enable) begin
            case (state)
                IDLE: begin
                    state          <= FETCH;
                    RD             <= 1'b1;
                    BusDirecciones <= pc;
                end
                FETCH: begin
                    fetch_IR       <= BusDatos;
                    RD             <= 1'b0;
                    BusDirecciones <= '0;
                    if (BusDatos == '0) begin
                        state      <= HALT;
                        fetch_Halt <= 1'b1;
                    end else begin
                        state         <= ISSUE;
                        fetch_IRValid <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (fetch_ExecDone) begin
                        state          <= FETCH;
                        pc             <= next_pc;
                        fetch_IRValid  <= 1'b0;
                        RD             <= 1'b1;
                        BusDirecciones <= next_pc;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a phase-level reference model checked
// every cycle, plus literal expectations for addresses, latency, stall and halt.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        exec_done = 1'b0;
    logic        taken = 1'b0;
    logic [31:0] bus_datos;
    logic [31:0] bus_dir;
    logic        rd, wr;
    logic [31:0] ir;
    logic        ir_valid;
    logic [31:0] pc;
    logic        halt;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    instruction_fetch_unit dut (
        .CLOCK_50         (clk),
        .RESET_InHigh     (rst),
        .fetch_Enable     (en),
        .fetch_ExecDone   (exec_done),
        .fetch_BranchTaken(taken),
        .BusDatos         (bus_datos),
        .BusDirecciones   (bus_dir),
        .RD               (rd),
        .WR               (wr),
        .fetch_IR         (ir),
        .fetch_IRValid    (ir_valid),
        .fetch_PC         (pc),
        .fetch_Halt       (halt)
    );

    // Program image: addcc words, a bneg at 0x820, a ba at 0x838, fin at 0x83C.
    function automatic logic [31:0] prog(input logic [31:0] a);
        if (a == 32'h820) return 32'h0CBF_FFFC;
        if (a == 32'h838) return 32'h10BF_FFFB;
        if (a >= 32'h800 && a < 32'h83C && a[1:0] == 2'b00) return 32'h8280_2001;
        return 32'h0;
    endfunction

    assign bus_datos = prog(bus_dir);

    // Reference model: phase 0 waiting, 1 reading memory, 2 word on offer, 3 stopped.
    int          m_phase;
    logic [31:0] m_pc;
    logic [31:0] m_ir;

    function automatic logic [31:0] target(input logic [31:0] cur, input logic [31:0] w,
                                           input logic br);
        int off;
        if (w[31:30] == 2'b00 && w[24:22] == 3'b010 && br) begin
            off = w[21] ? int'(w[21:0]) - (1 << 22) : int'(w[21:0]);
            return cur + 32'(off * 4);
        end
        return cur + 32'd4;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0;
            m_pc    <= 32'h800;
            m_ir    <= 32'h0;
        end else if (en) begin
            if (m_phase == 0) m_phase <= 1;
            else if (m_phase == 1) begin
                m_ir    <= prog(m_pc);
                m_phase <= (prog(m_pc) == 32'h0) ? 3 : 2;
            end else if (m_phase == 2 && exec_done) begin
                m_pc    <= target(m_pc, m_ir, taken);
                m_phase <= 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("rd", {31'b0, rd}, {31'b0, m_phase == 1});
        chk("wr", {31'b0, wr}, 32'h0);
        chk("addr", bus_dir, (m_phase == 1) ? m_pc : 32'h0);
        chk("valid", {31'b0, ir_valid}, {31'b0, m_phase == 2});
        chk("halt", {31'b0, halt}, {31'b0, m_phase == 3});
        chk("ir", ir, m_ir);
        chk("pc", pc, m_pc);
    end

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; exec_done = 1'b0; taken = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Wait for a word on offer at a known address, then optionally retire it.
    task automatic run_instr(input logic [31:0] addr, input logic br, input logic retire);
        bit found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (ir_valid) found = 1;
        end
        chk("issue_wait", {31'b0, found}, 32'h1);
        chk("issue_pc", pc, addr);
        if (retire) begin
            exec_done = 1'b1; taken = br;
            @(posedge clk); #2;
            exec_done = 1'b0; taken = 1'b0;
        end
    endtask

    logic [31:0] seq_addr [26];
    logic        seq_br   [26];

    initial begin
        seq_addr = '{32'h800, 32'h804, 32'h808, 32'h80C, 32'h810, 32'h814, 32'h818, 32'h81C,
                     32'h820, 32'h810, 32'h814, 32'h818, 32'h81C, 32'h820, 32'h824, 32'h828,
                     32'h82C, 32'h830, 32'h834, 32'h838, 32'h824, 32'h828, 32'h82C, 32'h830,
                     32'h834, 32'h838};
        seq_br   = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0,
                     0, 0, 0, 1, 0, 0, 0, 0, 0, 0};

        // Reset values and first-fetch latency.
        do_reset();
        chk("rst_pc", pc, 32'h800);
        en = 1'b1;
        @(negedge clk);
        chk("c1_rd", {31'b0, rd}, 32'h1);
        chk("c1_addr", bus_dir, 32'h800);
        @(negedge clk);
        chk("c2_valid", {31'b0, ir_valid}, 32'h1);
        chk("c2_ir", ir, 32'h8280_2001);
        chk("c2_pc", pc, 32'h800);

        // Sequential, taken/untaken bneg, taken ba, taken flag on non-Bicc, then fin.
        foreach (seq_addr[k]) run_instr(seq_addr[k], seq_br[k], 1'b1);
        begin
            bit seen = 0;
            for (int i = 0; i < 10 && !seen; i++) begin
                @(negedge clk);
                if (halt) seen = 1;
            end
            chk("halt_wait", {31'b0, seen}, 32'h1);
        end
        chk("halt_pc", pc, 32'h83C);
        chk("halt_ir", ir, 32'h0);
        repeat (3) begin
            exec_done = 1'b1; taken = 1'b1;
            @(negedge clk);
            exec_done = 1'b0; taken = 1'b0;
            @(negedge clk);
        end
        chk("halt_hold", {31'b0, halt}, 32'h1);
        chk("halt_hold_pc", pc, 32'h83C);

        // Asynchronous reset while 0x818 is on offer.
        do_reset();
        chk("rst2_pc", pc, 32'h800);
        en = 1'b1;
        for (int k = 0; k < 6; k++) run_instr(seq_addr[k], 1'b0, 1'b1);
        run_instr(32'h818, 1'b0, 1'b0);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'b0, ir_valid}, 32'h0);
        chk("arst_rd", {31'b0, rd}, 32'h0);
        chk("arst_addr", bus_dir, 32'h0);
        chk("arst_ir", ir, 32'h0);
        chk("arst_pc", pc, 32'h800);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("arst_refetch", bus_dir, 32'h800);

        // Stall in FETCH, then in ISSUE with ExecDone held.
        do_reset();
        en = 1'b1;
        @(posedge clk); #2;
        en = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_f_rd", {31'b0, rd}, 32'h1);
            chk("stall_f_addr", bus_dir, 32'h800);
        end
        en = 1'b1;
        @(posedge clk); #2;
        en = 1'b0;
        exec_done = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stall_i_valid", {31'b0, ir_valid}, 32'h1);
            chk("stall_i_ir", ir, 32'h8280_2001);
            chk("stall_i_pc", pc, 32'h800);
        end
        en = 1'b1;
        @(posedge clk); #2;
        exec_done = 1'b0;
        @(negedge clk);
        chk("resume_rd", {31'b0, rd}, 32'h1);
        chk("resume_addr", bus_dir, 32'h804);
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
